// File: rtl/master_slave_sink_pkg.sv
// Shared types for the master-slave sink: Sections FSM enum, reset value, data type.
// Optional MS_SINK_CHANGE_COUNT_EN adds a 16-bit change counter port.
package scam_model_types;
  typedef logic [31:0] scam_int_t;
endpackage

package masterslavesink_types;
  import scam_model_types::*;
  typedef enum logic {
    section_idle,
    section_emit
  } Sections;
  localparam scam_int_t MS_SINK_RESET_VAL = 32'd1337;
  localparam int MS_SINK_DEPTH = 4;
endpackage

// File: rtl/master_slave_sink_if.sv
// Shared-variable input and blocking notify/sync output of the sink.
// Carries chg_count only when MS_SINK_CHANGE_COUNT_EN is defined.
interface master_slave_sink_if;
  import scam_model_types::*;
  scam_int_t   s_in;
  scam_int_t   b_out_sig;
  logic        b_out_notify;
  logic        b_out_sync;
  logic        overflow;
`ifdef MS_SINK_CHANGE_COUNT_EN
  logic [15:0] chg_count;
`endif

  modport slave (
    input  s_in,
    input  b_out_sync,
    output b_out_sig,
    output b_out_notify,
`ifdef MS_SINK_CHANGE_COUNT_EN
    output chg_count,
`endif
    output overflow
  );

  modport master (
    output s_in,
    output b_out_sync,
    input  b_out_sig,
    input  b_out_notify,
`ifdef MS_SINK_CHANGE_COUNT_EN
    input  chg_count,
`endif
    input  overflow
  );
endinterface

// File: rtl/master_slave_sink_fifo.sv
// DEPTH x 32 circular queue with push/pop/full/empty/count and sync reset.
// Exposes the entry behind the head so the sink can register its next output.
module ms_sink_fifo
  import scam_model_types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  scam_int_t din,
  output scam_int_t head_nxt,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);
  scam_int_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head_nxt = mem[rd_ptr + AW'(1)];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
endmodule

// File: rtl/master_slave_sink.sv
// Turns a free-running shared variable into a queued notify/sync event stream.
// Define MS_SINK_CHANGE_COUNT_EN to add the chg_count change counter.
module master_slave_sink
  import scam_model_types::*;
  import masterslavesink_types::*;
#(
  parameter int        DEPTH     = MS_SINK_DEPTH,
  parameter scam_int_t RESET_VAL = MS_SINK_RESET_VAL,
  localparam int AW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  master_slave_sink_if.slave bus
);
  Sections   section_signal;
  Sections   nextsection_signal;
  scam_int_t last_val;
  scam_int_t sig_q;
  scam_int_t head_nxt;
  logic      ovf_q;
  logic      full;
  logic      empty;
  logic [AW:0] count;
  logic      chg;
  logic      notify;
  logic      pop;
  logic      push_ok;

  assign notify  = (section_signal == section_emit);
  assign pop     = notify && bus.b_out_sync;
  assign chg     = (bus.s_in != last_val);
  assign push_ok = chg && (!full || pop);

  ms_sink_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_ok),
    .pop      (pop),
    .din      (bus.s_in),
    .head_nxt (head_nxt),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) section_signal <= section_idle;
    else     section_signal <= nextsection_signal;
  end

  always_comb begin
    nextsection_signal = section_signal;
    unique case (section_signal)
      section_idle:
        if (push_ok) nextsection_signal = section_emit;
      section_emit:
        if (pop && count == (AW+1)'(1) && !push_ok)
          nextsection_signal = section_idle;
      default: nextsection_signal = section_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_val <= RESET_VAL;
      ovf_q    <= 1'b0;
    end else begin
      last_val <= bus.s_in;
      if (chg && full && !pop) ovf_q <= 1'b1;
    end
  end

  // Output register tracks the head; holds the last value once drained
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else if (push_ok && empty) begin
      sig_q <= bus.s_in;
    end else if (pop) begin
      if (count > (AW+1)'(1)) sig_q <= head_nxt;
      else if (push_ok)       sig_q <= bus.s_in;
    end
  end

  assign bus.b_out_sig    = sig_q;
  assign bus.b_out_notify = notify;
  assign bus.overflow     = ovf_q;

`ifdef MS_SINK_CHANGE_COUNT_EN
  logic [15:0] chg_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)      chg_cnt_q <= '0;
    else if (chg) chg_cnt_q <= chg_cnt_q + 16'd1;
  end
  assign bus.chg_count = chg_cnt_q;
`endif
endmodule

// File: tb/tb_master_slave_sink.sv
// Bench for master_slave_sink: queue-based reference model plus directed pins.
// Exercises MS_SINK_CHANGE_COUNT_EN paths when that macro is defined.
module tb_master_slave_sink;
  localparam int DEPTH = 4;
  localparam logic [31:0] RV = 32'd1337;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  master_slave_sink_if bus ();

  master_slave_sink dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mq[$];
  logic [31:0] mlast;
  logic [31:0] msig;
  bit          movf;
  logic [15:0] mcnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [31:0] s, input logic sy,
                            input logic r);
    bit pop;
    if (r) begin
      mq.delete();
      mlast = RV;
      msig = 0;
      movf = 0;
      mcnt = 0;
    end else begin
      pop = (mq.size() > 0) && sy;
      if (pop) void'(mq.pop_front());
      if (s != mlast) begin
        mcnt = mcnt + 16'd1;
        if (mq.size() < DEPTH) mq.push_back(s);
        else movf = 1;
      end
      mlast = s;
      if (mq.size() > 0) msig = mq[0];
    end
  endtask

  task automatic cmp_model();
    chk("notify", {31'b0, bus.b_out_notify}, {31'b0, mq.size() > 0});
    chk("sig", bus.b_out_sig, msig);
    chk("overflow", {31'b0, bus.overflow}, {31'b0, movf});
`ifdef MS_SINK_CHANGE_COUNT_EN
    chk("chg_count", {16'b0, bus.chg_count}, {16'b0, mcnt});
`endif
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic tick(input logic [31:0] s, input logic sy, input logic r);
    bus.s_in = s;
    bus.b_out_sync = sy;
    rst = r;
    @(posedge clk);
    model_step(s, sy, r);
    @(negedge clk);
    cmp_model();
  endtask

  initial begin
    logic [31:0] s;
    bus.s_in = RV;
    bus.b_out_sync = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tick(RV, 0, 1);
    chk("rst_notify", {31'b0, bus.b_out_notify}, 32'd0);
    chk("rst_sig", bus.b_out_sig, 32'd0);

    for (int i = 0; i < 10; i++) begin
      tick(RV, 1, 0);
      chk("idle_notify", {31'b0, bus.b_out_notify}, 32'd0);
      chk("idle_ovf", {31'b0, bus.overflow}, 32'd0);
    end

    tick(5, 1, 0);
    chk("chg5_notify", {31'b0, bus.b_out_notify}, 32'd1);
    chk("chg5_sig", bus.b_out_sig, 32'd5);
    tick(5, 1, 0);
    chk("pop5_notify", {31'b0, bus.b_out_notify}, 32'd0);
    chk("pop5_sig_hold", bus.b_out_sig, 32'd5);

    for (int k = 1; k <= 4; k++) tick(k, 0, 0);
    chk("full_model", mq.size(), 32'd4);
    chk("full_ovf", {31'b0, bus.overflow}, 32'd0);
    chk("full_head", bus.b_out_sig, 32'd1);
    tick(5, 0, 0);
    chk("drop_ovf", {31'b0, bus.overflow}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("drain_order", bus.b_out_sig, k);
      tick(5, 1, 0);
    end
    chk("drained", {31'b0, bus.b_out_notify}, 32'd0);

    for (int k = 11; k <= 14; k++) tick(k, 0, 0);
    tick(9, 1, 0);
    chk("fullpp_model", mq.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      s = (k == 3) ? 32'd9 : 32'(12 + k);
      chk("fullpp_order", bus.b_out_sig, s);
      tick(9, 1, 0);
    end
    chk("fullpp_empty", {31'b0, bus.b_out_notify}, 32'd0);

    tick(21, 0, 0);
    tick(22, 0, 0);
    tick(22, 1, 0);
    tick(RV, 1, 1);
    chk("mid_rst_notify", {31'b0, bus.b_out_notify}, 32'd0);
    chk("mid_rst_ovf", {31'b0, bus.overflow}, 32'd0);
    chk("mid_rst_sig", bus.b_out_sig, 32'd0);
    tick(RV, 1, 0);
    chk("rv_not_chg", {31'b0, bus.b_out_notify}, 32'd0);

`ifdef MS_SINK_CHANGE_COUNT_EN
    tick(RV, 0, 1);
    for (int k = 1; k <= 5; k++) tick(k, 0, 0);
    tick(6, 1, 0);
    chk("cnt6", {16'b0, bus.chg_count}, 32'd6);
    tick(RV, 1, 1);
    for (int k = 1; k <= 65536; k++) tick(k, 1, 0);
    chk("cnt_wrap", {16'b0, bus.chg_count}, 32'd0);
`endif

    tick(RV, 0, 1);
    for (int i = 0; i < 600; i++) begin
      s = ($urandom_range(0, 9) == 0) ? RV : 32'($urandom_range(0, 3));
      tick(s, 1'($urandom_range(0, 1)), ($urandom_range(0, 60) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
